// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor: per-channel HDLC framing monitor with statistics.
// Each channel tracks flags, stuffed zeros, aborts and frame length on its
// own serial line and keeps saturating frame / error / abort counters.
// Ports:
//   Clk, Rst        clock, async active-low reset
//   Line, BitValid  per-channel serial bit and bit strobe
//   CntClr          synchronous clear of all counters
//   RdSel           channel selected for counter readback
//   FlagDet, AbortDet, FrameDone, FrameErr  per-channel one-cycle pulses
//   Idle            per-channel level: 8 or more consecutive ones
//   RdFrameCnt, RdErrCnt, RdAbortCnt        counters of RdSel channel (1-cycle latency)
module hdlc_line_monitor #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned MIN_BYTES = 4,
  parameter int unsigned MAX_BYTES = 128,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                              Clk,
  input  logic                                              Rst,
  input  logic [CHANNELS-1:0]                               Line,
  input  logic [CHANNELS-1:0]                               BitValid,
  input  logic                                              CntClr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] RdSel,
  output logic [CHANNELS-1:0]                               FlagDet,
  output logic [CHANNELS-1:0]                               AbortDet,
  output logic [CHANNELS-1:0]                               FrameDone,
  output logic [CHANNELS-1:0]                               FrameErr,
  output logic [CHANNELS-1:0]                               Idle,
  output logic [CNT_W-1:0]                                  RdFrameCnt,
  output logic [CNT_W-1:0]                                  RdErrCnt,
  output logic [CNT_W-1:0]                                  RdAbortCnt
);

  localparam int unsigned SelW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SelN   = 1 << SelW;
  localparam int unsigned BitMax = (MAX_BYTES + 1) * 8 + 7;
  localparam int unsigned BitW   = $clog2(BitMax + 1);

  typedef enum logic {HUNT, SYNC} trkState_e;

  // Readback tables padded to a power of two; unused entries read zero.
  logic [SelN-1:0][CNT_W-1:0] frameCntV, errCntV, abortCntV;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
    trkState_e        state, stateNxt;
    logic [3:0]       runCnt, runNxt;
    logic [BitW-1:0]  bitCnt, bitNxt, nBits, nBytes;
    logic             flagC, abortC, doneC, errC;
    logic             flagQ, abortQ, doneQ, errQ, idleQ;
    logic [CNT_W-1:0] frameCnt, errCnt, abortCnt;

    // Tracker state register.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        state  <= HUNT;
        runCnt <= 4'd0;
        bitCnt <= '0;
      end else begin
        state  <= stateNxt;
        runCnt <= runNxt;
        bitCnt <= bitNxt;
      end
    end

    // Next-state: bitCnt includes the closing flag's leading 0 and six 1s,
    // hence the frame length is bitCnt - 7.
    always_comb begin
      stateNxt = state;
      runNxt   = runCnt;
      bitNxt   = bitCnt;
      flagC    = 1'b0;
      abortC   = 1'b0;
      doneC    = 1'b0;
      errC     = 1'b0;
      nBits    = bitCnt - BitW'(7);
      nBytes   = nBits >> 3;
      if (BitValid[ch]) begin
        if (Line[ch]) begin
          runNxt = (runCnt == 4'd15) ? runCnt : runCnt + 4'd1;
          if (state == SYNC && bitCnt != BitW'(BitMax)) bitNxt = bitCnt + BitW'(1);
          if (runCnt == 4'd6) begin
            stateNxt = HUNT;
            abortC   = (state == SYNC) && (bitCnt > BitW'(7));
          end
        end else begin
          runNxt = 4'd0;
          if (runCnt == 4'd6) begin
            flagC    = 1'b1;
            bitNxt   = '0;
            stateNxt = SYNC;
            // bitCnt <= 7 covers back-to-back and shared-zero flags.
            if (state == SYNC && bitCnt > BitW'(7)) begin
              if (nBits[2:0] != 3'd0 || nBytes < BitW'(MIN_BYTES) || nBytes > BitW'(MAX_BYTES))
                errC = 1'b1;
              else
                doneC = 1'b1;
            end
          end else if (runCnt != 4'd5 && state == SYNC && bitCnt != BitW'(BitMax)) begin
            bitNxt = bitCnt + BitW'(1);
          end
        end
      end
    end

    // Registered pulses and idle level.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        flagQ  <= 1'b0;
        abortQ <= 1'b0;
        doneQ  <= 1'b0;
        errQ   <= 1'b0;
        idleQ  <= 1'b0;
      end else begin
        flagQ  <= flagC;
        abortQ <= abortC;
        doneQ  <= doneC;
        errQ   <= errC;
        idleQ  <= (runNxt >= 4'd8);
      end
    end

    // Statistics counters; clear beats a coincident increment.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        frameCnt <= '0;
        errCnt   <= '0;
        abortCnt <= '0;
      end else if (CntClr) begin
        frameCnt <= '0;
        errCnt   <= '0;
        abortCnt <= '0;
      end else begin
        frameCnt <= satInc(frameCnt, doneC);
        errCnt   <= satInc(errCnt, errC);
        abortCnt <= satInc(abortCnt, abortC);
      end
    end

    assign FlagDet[ch]   = flagQ;
    assign AbortDet[ch]  = abortQ;
    assign FrameDone[ch] = doneQ;
    assign FrameErr[ch]  = errQ;
    assign Idle[ch]      = idleQ;
    assign frameCntV[ch] = frameCnt;
    assign errCntV[ch]   = errCnt;
    assign abortCntV[ch] = abortCnt;
  end

  for (genvar g = CHANNELS; g < SelN; g++) begin : gPad
    assign frameCntV[g] = '0;
    assign errCntV[g]   = '0;
    assign abortCntV[g] = '0;
  end

  // Counter readback register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RdFrameCnt <= '0;
      RdErrCnt   <= '0;
      RdAbortCnt <= '0;
    end else begin
      RdFrameCnt <= frameCntV[RdSel];
      RdErrCnt   <= errCntV[RdSel];
      RdAbortCnt <= abortCntV[RdSel];
    end
  end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb_hdlc_line_monitor: scoreboard bench for hdlc_line_monitor.
// Stimulus pushes expected pulse events and readback snapshots into queues;
// a negedge monitor pops and compares whenever the DUT reports something.
module tb_hdlc_line_monitor;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;
  localparam int FLAG = 0, ABORT = 1, DONE = 2, ERR = 3, IRISE = 4, IFALL = 5;

  logic          Clk;
  logic          Rst;
  logic [CH-1:0] Line, BitValid;
  logic          CntClr;
  logic [1:0]    RdSel;
  logic [CH-1:0] FlagDet, AbortDet, FrameDone, FrameErr, Idle;
  logic [CW-1:0] RdFrameCnt, RdErrCnt, RdAbortCnt;

  hdlc_line_monitor #(.CHANNELS(CH), .MIN_BYTES(4), .MAX_BYTES(128), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Line(Line), .BitValid(BitValid), .CntClr(CntClr),
    .RdSel(RdSel), .FlagDet(FlagDet), .AbortDet(AbortDet), .FrameDone(FrameDone),
    .FrameErr(FrameErr), .Idle(Idle), .RdFrameCnt(RdFrameCnt), .RdErrCnt(RdErrCnt),
    .RdAbortCnt(RdAbortCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed { logic [2:0] kind; logic [3:0] ch; } ev_t;
  typedef struct packed { logic allZero; logic [CW-1:0] f, e, a; logic [CH-1:0] idle; } rd_t;

  ev_t evQ[$];
  rd_t rdQ[$];
  logic txq[$];
  int   ones;
  int   nChecks = 0;
  int   nFail   = 0;
  logic rdReq, rdPend, endReq, sumReady;
  logic [CH-1:0] idlePrev;
  ev_t  e;
  rd_t  r;

  initial begin
    rdPend   = 1'b0;
    sumReady = 1'b0;
    idlePrev = '0;
  end

  always @(posedge Clk) rdPend <= rdReq;

  function automatic logic sig(input int k, input int c);
    case (k)
      FLAG:    return FlagDet[c];
      ABORT:   return AbortDet[c];
      DONE:    return FrameDone[c];
      ERR:     return FrameErr[c];
      IRISE:   return Idle[c] & ~idlePrev[c];
      default: return ~Idle[c] & idlePrev[c];
    endcase
  endfunction

  // Monitor: event scoreboard, readback snapshots, end-of-test queue drain.
  always @(negedge Clk) begin
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if (sig(k, c)) begin
          nChecks++;
          if (evQ.size() == 0) begin
            nFail++;
            $display("FAIL event: got unexpected kind=%0d ch=%0d, required none", k, c);
          end else begin
            e = evQ.pop_front();
            if (e.kind != 3'(k) || e.ch != 4'(c)) begin
              nFail++;
              $display("FAIL event: got kind=%0d ch=%0d, required kind=%0d ch=%0d",
                       k, c, e.kind, e.ch);
            end
          end
        end
      end
    end
    idlePrev <= Idle;
    if (rdPend) begin
      nChecks++;
      if (rdQ.size() == 0) begin
        nFail++;
        $display("FAIL readback: no expected snapshot queued");
      end else begin
        r = rdQ.pop_front();
        if (RdFrameCnt != r.f || RdErrCnt != r.e || RdAbortCnt != r.a) begin
          nFail++;
          $display("FAIL readback: got frame=%0d err=%0d abort=%0d, required %0d %0d %0d",
                   RdFrameCnt, RdErrCnt, RdAbortCnt, r.f, r.e, r.a);
        end
        nChecks++;
        if (Idle != r.idle) begin
          nFail++;
          $display("FAIL idle: got %b, required %b", Idle, r.idle);
        end
        if (r.allZero) begin
          nChecks++;
          if ((FlagDet | AbortDet | FrameDone | FrameErr) != '0) begin
            nFail++;
            $display("FAIL reset_pulses: got %b %b %b %b, required all 0",
                     FlagDet, AbortDet, FrameDone, FrameErr);
          end
        end
      end
    end
    if (endReq && !sumReady) begin
      nChecks++;
      if (evQ.size() != 0) begin
        nFail++;
        $display("FAIL missing_events: got %0d still pending, required 0", evQ.size());
      end
      nChecks++;
      if (rdQ.size() != 0) begin
        nFail++;
        $display("FAIL missing_reads: got %0d still pending, required 0", rdQ.size());
      end
      sumReady <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [CH-1:0] mask, input logic b, input logic clr);
    BitValid = mask;
    Line     = b ? mask : '0;
    CntClr   = clr;
    tick();
    BitValid = '0;
    Line     = '0;
    CntClr   = 1'b0;
  endtask

  function automatic void addFlag();
    txq.push_back(1'b0);
    for (int i = 0; i < 6; i++) txq.push_back(1'b1);
    txq.push_back(1'b0);
    ones = 0;
  endfunction

  // Data byte LSB first with transmitter zero insertion after five ones.
  function automatic void addByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      txq.push_back(b[i]);
      if (b[i]) begin
        ones++;
        if (ones == 5) begin
          txq.push_back(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endfunction

  function automatic void addRaw(input logic b, input int n);
    for (int i = 0; i < n; i++) txq.push_back(b);
  endfunction

  task automatic sendTx(input logic [CH-1:0] mask, input logic clrLast);
    for (int i = 0; i < txq.size(); i++)
      drive(mask, txq[i], clrLast && (i == txq.size() - 1));
    txq.delete();
  endtask

  function automatic void expEv(input int k, input int c);
    evQ.push_back('{kind: 3'(k), ch: 4'(c)});
  endfunction

  task automatic readChk(input int c, input logic z, input int f, input int er, input int a,
                         input logic [CH-1:0] idle);
    rdQ.push_back('{allZero: z, f: CW'(f), e: CW'(er), a: CW'(a), idle: idle});
    RdSel = 2'(c);
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
    tick();
  endtask

  initial begin
    Rst = 1'b0; Line = '0; BitValid = '0; CntClr = 1'b0; RdSel = '0;
    rdReq = 1'b0; endReq = 1'b0; ones = 0;
    repeat (2) @(posedge Clk);
    #1;
    readChk(0, 1'b1, 0, 0, 0, 4'b0000);
    Rst = 1'b1;
    tick(); tick();

    // Good 4-byte frame on ch0.
    addFlag(); repeat (4) addByte(8'hA5); addFlag();
    expEv(FLAG, 0); expEv(FLAG, 0); expEv(DONE, 0);
    sendTx(4'b0001, 1'b0);
    tick();
    readChk(0, 1'b0, 1, 0, 0, 4'b0000);

    // Stuffed 0xFF byte, shared back-to-back opening flag.
    addFlag(); addByte(8'hFF); addByte(8'h12); addByte(8'h34); addByte(8'h56); addFlag();
    expEv(FLAG, 0); expEv(FLAG, 0); expEv(DONE, 0);
    sendTx(4'b0001, 1'b0);
    readChk(0, 1'b0, 2, 0, 0, 4'b0000);

    // 35-bit frame, then 129-byte frame: both errors.
    addFlag(); addRaw(1'b0, 35); addFlag();
    expEv(FLAG, 0); expEv(FLAG, 0); expEv(ERR, 0);
    sendTx(4'b0001, 1'b0);
    readChk(0, 1'b0, 2, 1, 0, 4'b0000);
    addFlag(); repeat (129) addByte(8'h00); addFlag();
    expEv(FLAG, 0); expEv(FLAG, 0); expEv(ERR, 0);
    sendTx(4'b0001, 1'b0);
    readChk(0, 1'b0, 2, 2, 0, 4'b0000);

    // Abort after 2 bytes; following frame without flag is ignored.
    addFlag(); addByte(8'h00); addByte(8'h00); addRaw(1'b0, 1); addRaw(1'b1, 7);
    repeat (4) addByte(8'h00); addFlag();
    expEv(FLAG, 0); expEv(ABORT, 0); expEv(FLAG, 0);
    sendTx(4'b0001, 1'b0);
    readChk(0, 1'b0, 2, 2, 1, 4'b0000);

    // ch1 and ch3 finish together while counters are cleared.
    addFlag(); addByte(8'h3C); addByte(8'h81); addByte(8'h7E); addByte(8'h55); addFlag();
    expEv(FLAG, 1); expEv(FLAG, 3);
    expEv(FLAG, 1); expEv(FLAG, 3); expEv(DONE, 1); expEv(DONE, 3);
    sendTx(4'b1010, 1'b1);
    readChk(1, 1'b0, 0, 0, 0, 4'b0000);
    readChk(3, 1'b0, 0, 0, 0, 4'b0000);
    readChk(0, 1'b0, 0, 0, 0, 4'b0000);
    repeat (4) addByte(8'hC3); addFlag();
    expEv(FLAG, 1); expEv(DONE, 1);
    sendTx(4'b0010, 1'b0);
    readChk(1, 1'b0, 1, 0, 0, 4'b0000);

    // Idle on ch2 with gap cycles where Line=0 but BitValid=0.
    expEv(IRISE, 2); expEv(IFALL, 2);
    for (int i = 0; i < 16; i++) begin
      drive(4'b0100, 1'b1, 1'b0);
      tick();
      if (i == 6) readChk(2, 1'b0, 0, 0, 0, 4'b0000);
      if (i == 7) readChk(2, 1'b0, 0, 0, 0, 4'b0100);
    end
    drive(4'b0100, 1'b0, 1'b0);
    readChk(2, 1'b0, 0, 0, 0, 4'b0000);

    // Reset mid-frame drops the frame; a new flag is needed afterwards.
    addFlag(); addByte(8'h0F); addByte(8'hF0);
    expEv(FLAG, 0);
    sendTx(4'b0001, 1'b0);
    Rst = 1'b0;
    readChk(0, 1'b1, 0, 0, 0, 4'b0000);
    readChk(1, 1'b1, 0, 0, 0, 4'b0000);
    Rst = 1'b1;
    tick();
    addByte(8'h0F); addByte(8'hF0); addFlag();
    expEv(FLAG, 0);
    sendTx(4'b0001, 1'b0);
    readChk(0, 1'b0, 0, 0, 0, 4'b0000);
    repeat (4) addByte(8'h99); addFlag();
    expEv(FLAG, 0); expEv(DONE, 0);
    sendTx(4'b0001, 1'b0);
    readChk(0, 1'b0, 1, 0, 0, 4'b0000);

    repeat (4) tick();
    endReq = 1'b1;
    for (int i = 0; i < 10 && !sumReady; i++) tick();
    if (!sumReady) begin
      $display("FAIL summary_timeout: monitor did not drain, required drain within 10 cycles");
      $fatal(1, "monitor stalled");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
